// File: rtl/led_matrix_scanner.sv
// Row-scanning driver for a bicolour 8x8 LED matrix with per-frame snapshot and inter-row blanking.
// Optional PWM dimming is compiled in when LED_SCAN_DIM_EN is defined.
module led_matrix_scanner #(
    parameter int DWELL_CYCLES = 1024,
    parameter int BLANK_CYCLES = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [7:0][7:0] redarray,
    input  logic [7:0][7:0] greenarray,
`ifdef LED_SCAN_DIM_EN
    input  logic [2:0]      brightness,
`endif
    output logic [7:0]      row_sel,
    output logic [7:0]      red_col_n,
    output logic [7:0]      green_col_n,
    output logic            frame_done
);
    localparam int CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

    logic [CW-1:0]   cnt;
    logic [2:0]      row;
    logic [7:0][7:0] red_buf;
    logic [7:0][7:0] green_buf;

    logic            slot_end;
    logic            wrap;
    logic            drive_on;
    logic [7:0]      row_sel_d;
    logic [7:0]      red_col_n_d;
    logic [7:0]      green_col_n_d;

    assign slot_end = (cnt == CNT_LAST);
    // The only edge that refreshes the frame buffers: last cycle of row 7.
    assign wrap     = slot_end && (row == 3'd7);

`ifdef LED_SCAN_DIM_EN
    logic [2:0] pwm;
    logic [2:0] bright_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            pwm      <= 3'd0;
            bright_q <= 3'd7;
        end else begin
            pwm <= pwm + 3'd1;
            if (wrap) begin
                bright_q <= brightness;
            end
        end
    end

    assign drive_on = (cnt >= BLANK_END) && (pwm <= bright_q);
`else
    assign drive_on = (cnt >= BLANK_END);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            row       <= 3'd0;
            red_buf   <= '0;
            green_buf <= '0;
        end else begin
            if (slot_end) begin
                cnt <= '0;
                row <= row + 3'd1;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (wrap) begin
                red_buf   <= redarray;
                green_buf <= greenarray;
            end
        end
    end

    always_comb begin
        row_sel_d     = 8'h00;
        red_col_n_d   = 8'hFF;
        green_col_n_d = 8'hFF;
        if (drive_on) begin
            row_sel_d     = 8'b1 << row;
            red_col_n_d   = ~red_buf[row];
            green_col_n_d = ~green_buf[row];
        end
    end

    // Outputs lag the scan state by one cycle so every pin changes on a clock edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            row_sel     <= 8'h00;
            red_col_n   <= 8'hFF;
            green_col_n <= 8'hFF;
            frame_done  <= 1'b0;
        end else begin
            row_sel     <= row_sel_d;
            red_col_n   <= red_col_n_d;
            green_col_n <= green_col_n_d;
            frame_done  <= wrap;
        end
    end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Self-checking bench for led_matrix_scanner: directed scenarios plus random frame updates, checked
// against a frame-position reference model. Define LED_SCAN_DIM_EN to also exercise dimming.
module tb_led_matrix_scanner;
    localparam int DW    = 8;
    localparam int BL    = 2;
    localparam int FRAME = 8 * DW;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [7:0][7:0] redarray = '0;
    logic [7:0][7:0] greenarray = '0;
    logic [2:0]      brightness = 3'd7;
    logic [7:0]      row_sel;
    logic [7:0]      red_col_n;
    logic [7:0]      green_col_n;
    logic            frame_done;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: position within the frame of the current scan slot, and the frame being shown.
    int              m_pos = 0;
    logic [7:0][7:0] shown_red = '0;
    logic [7:0][7:0] shown_green = '0;
    int              pwm_m = 0;
    logic [2:0]      bright_m = 3'd7;
    logic [7:0]      prev_row = 8'h00;
    bit              seen_row = 1'b0;
    int              blank_run = 0;

    led_matrix_scanner #(.DWELL_CYCLES(DW), .BLANK_CYCLES(BL)) dut (
        .clk         (clk),
        .reset       (reset),
        .redarray    (redarray),
        .greenarray  (greenarray),
`ifdef LED_SCAN_DIM_EN
        .brightness  (brightness),
`endif
        .row_sel     (row_sel),
        .red_col_n   (red_col_n),
        .green_col_n (green_col_n),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h pos=%0d", tag, obs, exp, m_pos);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock edge: predict the outputs from the model, advance the model, compare.
    task automatic tick();
        logic       rst_e;
        logic [7:0] e_row, e_red, e_grn;
        logic       e_fd;
        bit         on;
        int         r;
        rst_e = reset;
        @(posedge clk);
        #1;
        e_row = 8'h00;
        e_red = 8'hFF;
        e_grn = 8'hFF;
        e_fd  = 1'b0;
        if (rst_e) begin
            m_pos       = 0;
            shown_red   = '0;
            shown_green = '0;
            pwm_m       = 0;
            bright_m    = 3'd7;
            seen_row    = 1'b0;
            blank_run   = 0;
        end else begin
            r  = m_pos / DW;
            on = (m_pos % DW) >= BL;
`ifdef LED_SCAN_DIM_EN
            on    = on && (pwm_m <= int'(bright_m));
            pwm_m = (pwm_m + 1) % 8;
`endif
            if (on) begin
                e_row = 8'b1 << r;
                e_red = ~shown_red[r];
                e_grn = ~shown_green[r];
            end
            e_fd = (m_pos == FRAME - 1);
            if (e_fd) begin
                shown_red   = redarray;
                shown_green = greenarray;
                bright_m    = brightness;
            end
            m_pos = (m_pos + 1) % FRAME;
        end
        check8("row_sel", row_sel, e_row);
        check8("red_col_n", red_col_n, e_red);
        check8("green_col_n", green_col_n, e_grn);
        check8("frame_done", {7'd0, frame_done}, {7'd0, e_fd});
        check8("onehot0", {7'd0, $onehot0(row_sel)}, 8'd1);
`ifndef LED_SCAN_DIM_EN
        if (!rst_e) begin
            if (row_sel != 8'h00) begin
                if (prev_row == 8'h00 && seen_row) check_int("blank_run", blank_run, BL);
                if (prev_row != 8'h00) check8("row_step", row_sel, prev_row);
                seen_row  = 1'b1;
                blank_run = 0;
            end else begin
                blank_run++;
            end
        end
`endif
        prev_row = row_sel;
    endtask

    initial begin
        int cnt08;
        int lit;

        // Reset held for three edges with garbage on the inputs.
        redarray   = {$urandom, $urandom};
        greenarray = {$urandom, $urandom};
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;

        // Single pixel loaded before the first wrap; first frame itself must stay dark.
        redarray    = '0;
        greenarray  = '0;
        redarray[3] = 8'h80;
        lit = 0;
        for (int i = 0; i < FRAME; i++) begin
            tick();
            if (row_sel != 8'h00) lit += (red_col_n != 8'hFF || green_col_n != 8'hFF) ? 1 : 0;
        end
        check_int("first_frame_dark", lit, 0);
        check8("frame_done_at_64", {7'd0, frame_done}, 8'd1);

        // Second frame: row 3 lit for six drive cycles with the leftmost red LED.
        cnt08 = 0;
        for (int i = 0; i < FRAME - 1; i++) begin
            tick();
            if (row_sel == 8'h08) begin
                cnt08++;
                check8("row3_red", red_col_n, 8'h7F);
            end
        end
        check_int("row3_drive_cycles", cnt08, DW - BL);

        // Tear-free: green row 0 changes mid-frame (row 4) and must wait for the next frame.
        greenarray[0] = 8'h01;
        for (int i = 0; i < FRAME; i++) tick();
        for (int i = 0; i < FRAME && m_pos != 4 * DW + 3; i++) tick();
        greenarray[0] = 8'hFF;
        for (int i = 0; i < FRAME; i++) begin
            tick();
            if (frame_done) break;
        end
        check8("tear_frame_done", {7'd0, frame_done}, 8'd1);
        for (int i = 0; i < BL + 1; i++) tick();
        check8("green_row0_new", green_col_n, 8'h00);

        // Random frame content changes at random moments.
        for (int i = 0; i < 4 * FRAME; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                redarray   = {$urandom, $urandom};
                greenarray = {$urandom, $urandom};
            end
            tick();
        end

        // Reset mid-frame at row 5, cnt 6.
        for (int i = 0; i < FRAME && m_pos != 5 * DW + 6; i++) tick();
        reset = 1'b1;
        tick();
        check8("midreset_row_sel", row_sel, 8'h00);
        reset = 1'b0;
        lit = 0;
        for (int i = 0; i < FRAME; i++) begin
            tick();
            if (row_sel != 8'h00) lit += (red_col_n != 8'hFF || green_col_n != 8'hFF) ? 1 : 0;
        end
        check_int("post_reset_dark", lit, 0);
        for (int i = 0; i < FRAME; i++) tick();

`ifdef LED_SCAN_DIM_EN
        // Dimmed frames, then full brightness again.
        brightness = 3'd3;
        for (int i = 0; i < 3 * FRAME; i++) tick();
        brightness = 3'd7;
        for (int i = 0; i < 2 * FRAME; i++) tick();
        for (int i = 0; i < 2 * FRAME; i++) begin
            if ($urandom_range(0, 31) == 0) brightness = 3'($urandom_range(0, 7));
            tick();
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
